// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet/IPv4/UDP framing constants and receive state codes,
// shared by the UDP receive and transmit paths.
package eth_pkg;
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_MAC      = 4'd2,
        ST_IP_HDR   = 4'd3,
        ST_UDP_HDR  = 4'd4,
        ST_DATA     = 4'd5,
        ST_TRAIL    = 4'd6,
        ST_CHECK    = 4'd7,
        ST_DROP     = 4'd8
    } eth_state_t;
    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
endpackage

// File: rtl/udp_receive_if.sv
// udp_receive_if: PHY receive byte stream in, payload RAM writes and frame status out.
interface udp_receive_if;
    logic        rxdv;
    logic        rxer;
    logic [7:0]  rxd;
    logic        ram_wr_en;
    logic [8:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [15:0] rx_data_length;
    logic        rx_done;
    logic        rx_err;
    logic [3:0]  rx_state;
    modport master (output rxdv, rxer, rxd,
                    input  ram_wr_en, ram_wr_addr, ram_wr_data, rx_data_length, rx_done, rx_err, rx_state);
    modport slave  (input  rxdv, rxer, rxd,
                    output ram_wr_en, ram_wr_addr, ram_wr_data, rx_data_length, rx_done, rx_err, rx_state);
endinterface

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide Ethernet CRC-32, bits taken LSB first into an MSB-first register,
// so a frame ending in a correct FCS leaves the fixed residue.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);
    logic [31:0] w_next;

    always_comb begin
        w_next = crc;
        for (int i = 0; i < 8; i++)
            w_next = {w_next[30:0], 1'b0} ^ ((w_next[31] ^ d[i]) ? CRC_POLY : 32'h0);
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr)      crc <= 32'hFFFFFFFF;
        else if (init) crc <= 32'hFFFFFFFF;
        else if (en)   crc <= w_next;
endmodule

// File: rtl/udp_receive.sv
// udp_receive: filters Ethernet/IPv4/UDP frames for this station, packs the UDP payload
// big-endian into 32-bit RAM words and reports each frame as accepted or rejected.
module udp_receive
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80003,
    parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
    input logic          clk,
    input logic          clr,
    udp_receive_if.slave bus
);
    eth_state_t  r_state, w_next;
    logic [15:0] r_cnt, r_len, r_rx_len;
    logic [39:0] r_sh;
    logic [47:0] w_sh;
    logic [31:0] w_crc, r_wr_data;
    logic [8:0]  r_wr_addr;
    logic        r_armed, r_wr_en, r_done, r_err;
    logic        w_wr, w_done, w_err, w_last, w_start, w_crc_init, w_crc_en;

    // w_sh holds the most recent six bytes, current byte in [7:0]
    assign w_sh       = {r_sh, bus.rxd};
    assign w_last     = r_cnt == r_len - 16'd9;
    assign w_start    = r_state == ST_IDLE && w_next == ST_PREAMBLE;
    assign w_crc_init = r_state inside {ST_IDLE, ST_PREAMBLE};
    assign w_crc_en   = bus.rxdv && r_state inside {[ST_MAC:ST_TRAIL]};

    assign bus.ram_wr_en      = r_wr_en;
    assign bus.ram_wr_addr    = r_wr_addr;
    assign bus.ram_wr_data    = r_wr_data;
    assign bus.rx_data_length = r_rx_len;
    assign bus.rx_done        = r_done;
    assign bus.rx_err         = r_err;
    assign bus.rx_state       = r_state;

    eth_crc32_d8 u_crc (
        .clk  (clk),
        .clr  (clr),
        .init (w_crc_init),
        .en   (w_crc_en),
        .d    (bus.rxd),
        .crc  (w_crc)
    );

    always_ff @(posedge clk or negedge clr)
        if (!clr) r_state <= ST_IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        if (r_state inside {[ST_PREAMBLE:ST_DATA]} && !bus.rxdv) begin
            w_next = ST_IDLE;
            w_err  = 1'b1;
        end else if (!(r_state inside {ST_IDLE, ST_DROP}) && bus.rxdv && bus.rxer) begin
            w_next = ST_DROP;
        end else begin
            case (r_state)
                ST_IDLE:     w_next = (r_armed && bus.rxdv && bus.rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_IDLE;
                ST_PREAMBLE: w_next = (bus.rxd != (r_cnt == 16'd6 ? ETH_SFD : ETH_PREAMBLE)) ? ST_DROP :
                                      (r_cnt == 16'd6) ? ST_MAC : ST_PREAMBLE;
                ST_MAC:      w_next = ((r_cnt == 16'd5 && w_sh != LOCAL_MAC && w_sh != '1) ||
                                       (r_cnt == 16'd13 && w_sh[15:0] != ETH_TYPE_IPV4)) ? ST_DROP :
                                      (r_cnt == 16'd13) ? ST_IP_HDR : ST_MAC;
                ST_IP_HDR:   w_next = ((r_cnt == 16'd0 && bus.rxd != IP_VER_IHL) ||
                                       (r_cnt == 16'd9 && bus.rxd != IP_PROTO_UDP) ||
                                       (r_cnt == 16'd19 && w_sh[31:0] != LOCAL_IP)) ? ST_DROP :
                                      (r_cnt == 16'd19) ? ST_UDP_HDR : ST_IP_HDR;
                ST_UDP_HDR:  w_next = ((r_cnt == 16'd3 && w_sh[15:0] != LOCAL_PORT) ||
                                       (r_cnt == 16'd5 && w_sh[15:0] < 16'd8)) ? ST_DROP :
                                      (r_cnt != 16'd7) ? ST_UDP_HDR :
                                      (r_len == 16'd8) ? ST_TRAIL : ST_DATA;
                ST_DATA: begin
                    w_wr   = r_cnt[1:0] == 2'd3 || w_last;
                    w_next = w_last ? ST_TRAIL : ST_DATA;
                end
                ST_TRAIL:    w_next = bus.rxdv ? ST_TRAIL : ST_CHECK;
                ST_CHECK: begin
                    w_done = w_crc == CRC_RESIDUE;
                    w_err  = w_crc != CRC_RESIDUE;
                    w_next = ST_IDLE;
                end
                ST_DROP: begin
                    w_err  = !bus.rxdv;
                    w_next = bus.rxdv ? ST_DROP : ST_IDLE;
                end
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    // r_armed keeps a frame already in flight at reset release from being picked up mid-way
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_len     <= '0;
            r_rx_len  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_armed   <= r_armed | ~bus.rxdv;
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
            r_sh      <= w_sh[39:0];
            r_len     <= (r_state == ST_UDP_HDR && r_cnt == 16'd5) ? w_sh[15:0] : r_len;
            r_rx_len  <= w_done ? r_len : r_rx_len;
            r_wr_en   <= w_wr;
            r_wr_addr <= w_start ? '0 : r_wr_addr + 9'(r_wr_en);
            r_wr_data <= w_wr ? w_sh[31:0] << {~r_cnt[1:0], 3'b000} : r_wr_data;
            r_done    <= w_done;
            r_err     <= w_err;
        end
endmodule

// File: doc/udp_receive.md
UDP_RECEIVE -- requirements
Module: udp_receive

Interface
REQ-001 Parameter LOCAL_MAC, default 48'h000A3501FEC0, station MAC address accepted as destination.
REQ-002 Parameter LOCAL_IP, default 32'hC0A80003, IPv4 address accepted as destination.
REQ-003 Parameter LOCAL_PORT, default 16'h1F90, UDP destination port accepted.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 rxdv  input  1  receive data valid, high for the whole frame including preamble.
REQ-007 rxer  input  1  receive error from the PHY.
REQ-008 rxd  input  8  received byte, sampled when rxdv high.
REQ-009 ram_wr_en  output  1  one-cycle payload word write strobe.
REQ-010 ram_wr_addr  output  9  payload word address.
REQ-011 ram_wr_data  output  32  payload word, first byte in [31:24].
REQ-012 rx_data_length  output  16  UDP length field of the last accepted frame.
REQ-013 rx_done  output  1  one-cycle pulse, frame accepted.
REQ-014 rx_err  output  1  one-cycle pulse, frame rejected.
REQ-015 rx_state  output  4  current state code.

Function
REQ-016 States SHALL be IDLE(0), PREAMBLE(1), MAC(2), IP_HDR(3), UDP_HDR(4), DATA(5), TRAIL(6), CHECK(7), DROP(8).
REQ-017 IDLE->PREAMBLE SHALL occur when rxdv=1 and rxd=8'h55.
REQ-018 PREAMBLE SHALL require six further 8'h55 bytes then 8'hD5 and go to MAC; any other byte goes to DROP.
REQ-019 MAC SHALL take 14 bytes; destination SHALL equal LOCAL_MAC or FF:FF:FF:FF:FF:FF, and type SHALL equal 16'h0800.
REQ-020 IP_HDR SHALL take 20 bytes; it SHALL require byte0=8'h45, protocol=8'h11, and destination address=LOCAL_IP. The checksum field is not verified.
REQ-021 UDP_HDR SHALL take 8 bytes; it SHALL require destination port=LOCAL_PORT and SHALL latch length L. L<8 is a mismatch.
REQ-022 On a mismatch in REQ-019..021 the block SHALL go to DROP at the next byte; DROP waits for rxdv=0 and then pulses rx_err.
REQ-023 DATA SHALL take L-8 bytes and pack them big-endian.
REQ-024 ram_wr_en SHALL pulse in the cycle after each 4th byte. A final partial word SHALL be zero-padded and written in the cycle after the last payload byte.
REQ-025 ram_wr_addr SHALL start at 0 each frame, increment after each write, and wrap 511->0.
REQ-026 L=8 SHALL skip DATA with no writes.
REQ-027 TRAIL SHALL consume pad and FCS bytes until rxdv=0, then enter CHECK.
REQ-028 CRC-32 (poly 04C11DB7, init FFFFFFFF, reflected) SHALL cover bytes from destination MAC through FCS. The residue SHALL equal 32'hC704DD7B.
REQ-029 CHECK SHALL last one cycle. On good residue it SHALL pulse rx_done and update rx_data_length to L; otherwise it SHALL pulse rx_err. It then returns to IDLE.
REQ-030 rxdv falling in any state from PREAMBLE through DATA SHALL cause an rx_err pulse the next cycle, then IDLE.
REQ-031 rxer=1 while rxdv=1 in any non-IDLE state SHALL force DROP.
REQ-032 rx_done and rx_err SHALL never be high together. Words already written for a rejected frame are not retracted.

Reset
REQ-033 clr=0 SHALL asynchronously set all outputs to 0 and state to IDLE, and preset the CRC to FFFFFFFF; reset mid-frame discards the frame without a pulse.
REQ-034 After reset release, a frame already in progress SHALL be ignored until rxdv=0 followed by a new preamble.

Structure
REQ-035 State codes, 8'h55/8'hD5, 16'h0800, 8'h45, 8'h11 and the CRC residue SHALL reside in shared package eth_pkg, also used by the transmitter.
REQ-036 CRC SHALL be one sub-module eth_crc32_d8 (inputs clk, clr, init, en, d[7:0]; output crc[31:0]).

Verification
REQ-037 Frame to LOCAL_MAC/IP/port with 8-byte payload 01..08 and good FCS -> writes 32'h01020304@0 and 32'h05060708@1, rx_done=1, rx_data_length=16.
REQ-038 5-byte payload AA BB CC DD EE -> 32'hAABBCCDD@0 and 32'hEE000000@1, then rx_done.
REQ-039 Same frame with one FCS bit flipped -> identical writes, rx_err pulse, no rx_done.
REQ-040 Destination port 16'h1F91 -> no writes, rx_err after rxdv falls.
REQ-041 rxdv dropped after 3 payload bytes -> rx_err next cycle, no write, state IDLE; the next good frame is accepted with address restarting at 0.
REQ-042 clr asserted mid-DATA -> outputs 0 immediately, no pulse; a following good frame gives rx_done.
